arc4_ksa_fsm: RTL and testbench

//   ARC4 key-scheduling controller: fills S RAM (s[i]=i), then runs the 256-step KSA swap loop.

---
 rtl/arc4_pkg.sv | 32 +++
 rtl/arc4_key_sel.sv | 39 +++
 rtl/arc4_ksa_fsm.sv | 171 +++++++++++++++++
 tb/tb_arc4_ksa_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// ---------------------------------------------------------------------------
// arc4_pkg
//   Shared definitions for the ARC4 key-scheduling controller:
//     - arc4_ksa_state_t : controller state encoding
//     - S_DEPTH, ADDR_W  : S array geometry (fixed 256 x 8)
//     - KEY_BYTES_DEFAULT: default secret key length in bytes
//     - kidx_width()     : width of the key-index counter (at least 1 bit)
// ---------------------------------------------------------------------------
package arc4_pkg;

    localparam int S_DEPTH           = 256;
    localparam int ADDR_W            = 8;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WAIT_I,
        RD_J,
        WAIT_J,
        SWAP_J,
        SWAP_I,
        DONE
    } arc4_ksa_state_t;

    // A one-byte key still needs a 1-bit index so the counter stays legal.
    function automatic int kidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arc4_key_sel.sv
// ---------------------------------------------------------------------------
// arc4_key_sel
//   Combinational selection of one key byte by key index. Key byte 0 is the
//   most significant byte of the key vector.
// Ports:
//   key      in  8*KEY_BYTES  latched secret key
//   idx      in  KIDX_W       key byte index (0..KEY_BYTES-1)
//   key_byte out 8            selected key byte
// ---------------------------------------------------------------------------
module arc4_key_sel
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int KIDX_W    = kidx_width(KEY_BYTES)
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [KIDX_W-1:0]      idx,
    output logic [7:0]             key_byte
);

    logic [7:0] key_bytes [KEY_BYTES];

    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_byte
            assign key_bytes[gi] = key[8*(KEY_BYTES-gi)-1 -: 8];
        end
    endgenerate

    // Explicit compare per byte keeps non-power-of-two key lengths safe.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (idx == KIDX_W'(b)) begin
                key_byte = key_bytes[b];
            end
        end
    end

endmodule

// File: rtl/arc4_ksa_fsm.sv
// ---------------------------------------------------------------------------
// arc4_ksa_fsm
//   ARC4 key-scheduling controller. Optionally fills the S RAM with the
//   identity permutation, then runs the 256-step KSA swap loop against a
//   single-port 256x8 RAM whose read data arrives one cycle after the
//   address. Each KSA step takes 6 cycles:
//     RD_I -> WAIT_I -> RD_J -> WAIT_J -> SWAP_J -> SWAP_I
//
//   Build option: define ARC4_INIT_PHASE_EN to include the INIT phase
//   (256 writes s[i]=i). Without it the RAM must be preloaded with the
//   identity permutation and IDLE goes straight to RD_I.
//
// Ports:
//   clock    in   1            system clock, rising edge
//   reset_n  in   1            asynchronous active-low reset
//   start    in   1            begin request, sampled only in IDLE
//   key      in   8*KEY_BYTES  secret key, latched on accepted start
//   finish   out  1            one-cycle pulse when S is complete
//   busy     out  1            high from accepted start through finish
//   address  out  8            S RAM address
//   data     out  8            S RAM write data
//   s_wren   out  1            S RAM write enable
//   s_q      in   8            S RAM read data (1-cycle latency)
// ---------------------------------------------------------------------------
module arc4_ksa_fsm
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   finish,
    output logic                   busy,
    output logic [ADDR_W-1:0]      address,
    output logic [7:0]             data,
    output logic                   s_wren,
    input  logic [7:0]             s_q
);

    localparam int                KIDX_W   = kidx_width(KEY_BYTES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(S_DEPTH - 1);

    arc4_ksa_state_t        state_reg, state_next;
    logic [ADDR_W-1:0]      i_reg, i_next;
    logic [ADDR_W-1:0]      j_reg, j_next;
    logic [KIDX_W-1:0]      k_reg, k_next;
    logic [7:0]             si_reg, si_next;
    logic [7:0]             sj_reg, sj_next;
    logic [8*KEY_BYTES-1:0] key_reg, key_next;
    logic [7:0]             key_byte;

    arc4_key_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KIDX_W    (KIDX_W)
    ) u_key_sel (
        .key      (key_reg),
        .idx      (k_reg),
        .key_byte (key_byte)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            si_reg    <= '0;
            sj_reg    <= '0;
            key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            si_reg    <= si_next;
            sj_reg    <= sj_next;
            key_reg   <= key_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        si_next    = si_reg;
        sj_next    = sj_reg;
        key_next   = key_reg;
        address    = '0;
        data       = '0;
        s_wren     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_next = key;
                    i_next   = '0;
                    j_next   = '0;
                    k_next   = '0;
`ifdef ARC4_INIT_PHASE_EN
                    state_next = INIT;
`else
                    state_next = RD_I;
`endif
                end
            end
`ifdef ARC4_INIT_PHASE_EN
            INIT: begin
                address = i_reg;
                data    = i_reg;
                s_wren  = 1'b1;
                i_next  = i_reg + 8'd1;   // wraps to 0 after the last entry
                if (i_reg == LAST_IDX) begin
                    state_next = RD_I;
                end
            end
`endif
            RD_I: begin
                address    = i_reg;
                state_next = WAIT_I;
            end
            WAIT_I: begin
                address    = i_reg;
                state_next = RD_J;
            end
            RD_J: begin
                // s_q holds s[i]; the new j is presented to the RAM right away.
                si_next    = s_q;
                j_next     = j_reg + s_q + key_byte;
                address    = j_next;
                state_next = WAIT_J;
            end
            WAIT_J: begin
                address    = j_reg;
                state_next = SWAP_J;
            end
            SWAP_J: begin
                // s_q holds s[j]; when i==j it equals si, so the swap is a no-op.
                sj_next    = s_q;
                address    = j_reg;
                data       = si_reg;
                s_wren     = 1'b1;
                state_next = SWAP_I;
            end
            SWAP_I: begin
                address = i_reg;
                data    = sj_reg;
                s_wren  = 1'b1;
                if (i_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    i_next     = i_reg + 8'd1;
                    k_next     = (k_reg == KIDX_W'(KEY_BYTES - 1)) ? '0 : k_reg + KIDX_W'(1);
                    state_next = RD_I;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign finish = (state_reg == DONE);
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_arc4_ksa_fsm.sv
// ---------------------------------------------------------------------------
// tb_arc4_ksa_fsm
//   Self-checking bench for arc4_ksa_fsm. Models the S RAM (1-cycle read
//   latency) and compares the final S contents with a software ARC4 KSA.
//   Honours ARC4_INIT_PHASE_EN: with it the RAM starts with random junk,
//   without it the RAM is preloaded with the identity permutation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arc4_ksa_fsm;

`ifdef ARC4_INIT_PHASE_EN
    localparam int INIT_W  = 256;
    localparam int EXP_FIN = 1793;
`else
    localparam int INIT_W  = 0;
    localparam int EXP_FIN = 1537;
`endif
    localparam int EXP_WR = INIT_W + 512;
    localparam int LIMIT  = 4000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] key;
    logic        finish;
    logic        busy;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        s_wren;
    logic [7:0]  s_q;

    int n_checks = 0;
    int n_err    = 0;
    int bad_wren = 0;

    arc4_ksa_fsm dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .key     (key),
        .finish  (finish),
        .busy    (busy),
        .address (address),
        .data    (data),
        .s_wren  (s_wren),
        .s_q     (s_q)
    );

    always #5 clock = ~clock;

    // ---------------- S RAM model and write recorder ----------------
    logic [7:0]  mem      [256];
    logic [7:0]  load_img [256];
    logic        load_en = 1'b0;
    logic        rec_en  = 1'b0;
    logic [15:0] wq [$];

    always @(posedge clock) begin
        if (load_en) begin
            for (int a = 0; a < 256; a++) mem[a] <= load_img[a];
        end else begin
            if (s_wren) mem[address] <= data;
            s_q <= mem[address];
        end
        if (rec_en && s_wren) wq.push_back({address, data});
    end

    // A write while the controller claims to be idle is always wrong.
    always @(negedge clock) begin
        if (reset_n && s_wren && !busy) bad_wren++;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_s [256];

    task automatic ksa_ref(input logic [23:0] k);
        int j, kb;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
            j = (j + int'(exp_s[i]) + kb) % 256;
            t = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic check(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic preload();
        for (int a = 0; a < 256; a++) begin
`ifdef ARC4_INIT_PHASE_EN
            load_img[a] = 8'($urandom);
`else
            load_img[a] = 8'(a);
`endif
        end
        @(negedge clock); load_en = 1'b1;
        @(negedge clock); load_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
    endtask

    // mode 0: plain run; 1: start pulse and key changes mid-run;
    // 2: start held high throughout (restart after DONE expected)
    task automatic run_case(input string nm, input logic [23:0] k, input int mode,
                            input int exp_fin, input int exp_wr);
        int cyc, fin_cyc, pulses, diff;
        bit done;
        preload();
        wq.delete();
        ksa_ref(k);
        key = k; start = 1'b1; rec_en = 1'b1;
        @(posedge clock); cyc = 1;
        @(negedge clock);
        if (mode != 2) start = 1'b0;
        check({nm, "_busy_start"}, busy, 1);
        fin_cyc = -1; pulses = 0; done = 1'b0;
        while (!done && cyc < LIMIT) begin
            if (finish) begin
                pulses++;
                if (fin_cyc < 0) begin
                    fin_cyc = cyc;
                    check({nm, "_busy_at_finish"}, busy, 1);
                end
            end
            if (mode == 1 && cyc == 500) begin start = 1'b1; key = ~k; end
            if (mode == 1 && cyc == 501) start = 1'b0;
            if (mode == 1 && cyc == 700) key = 24'($urandom);
            if (fin_cyc > 0 && cyc == fin_cyc + 1) begin
                check({nm, "_busy_after"}, busy, 0);
                done = 1'b1;
            end else begin
                @(posedge clock); cyc++;
                @(negedge clock);
            end
        end
        rec_en = 1'b0;
        check({nm, "_finish_cycle"}, fin_cyc, exp_fin);
        check({nm, "_finish_pulses"}, pulses, 1);
        check({nm, "_write_count"}, wq.size(), exp_wr);
        diff = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) diff++;
        check({nm, "_s_bytes_wrong"}, diff, 0);
        if (mode == 2) begin
            @(posedge clock); @(negedge clock);
            check({nm, "_restart_busy"}, busy, 1);
            start = 1'b0;
            pulse_reset();
        end
        $display("run %s key=%06h mode=%0d finish_cycle=%0d writes=%0d s_diff=%0d",
                 nm, k, mode, fin_cyc, wq.size(), diff);
    endtask

    typedef struct {
        string       name;
        logic [23:0] key;
        int          mode;
        int          exp_fin;
        int          exp_wr;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int cyc, bad;
        logic [23:0] rk;

        vecs[0] = '{"key033C",    24'h00033C, 1, EXP_FIN, EXP_WR};
        vecs[1] = '{"key_hold",   24'hA55A01, 2, EXP_FIN, EXP_WR};
        vecs[2] = '{"key_ffffff", 24'hFFFFFF, 0, EXP_FIN, EXP_WR};

        // ---- reset state ----
        reset_n = 1'b1; start = 1'b0; key = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_finish", finish, 0);
        check("rst_busy", busy, 0);
        check("rst_wren", s_wren, 0);
        check("rst_address", address, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_hold_busy", busy, 0);
        check("idle_hold_wren", s_wren, 0);
        check("idle_hold_finish", finish, 0);
        $display("txn reset: busy=%0d s_wren=%0d finish=%0d address=%0d",
                 busy, s_wren, finish, address);

        // ---- key 000000: hand-derived swap pattern ----
        run_case("key000000", 24'h000000, 0, EXP_FIN, EXP_WR);
`ifdef ARC4_INIT_PHASE_EN
        bad = 0;
        for (int a = 0; a < 256; a++) if (wq[a] !== {8'(a), 8'(a)}) bad++;
        check("init_writes_wrong", bad, 0);
`endif
        check("k0_step0_selfswap", wq[INIT_W + 0], 16'h0000);
        check("k0_step1_selfswap", wq[INIT_W + 3], 16'h0101);
        check("k0_step2_write_j", wq[INIT_W + 4], 16'h0302);
        check("k0_step2_write_i", wq[INIT_W + 5], 16'h0203);

        // ---- table-driven runs ----
        for (int v = 0; v < 3; v++) begin
            run_case(vecs[v].name, vecs[v].key, vecs[v].mode, vecs[v].exp_fin, vecs[v].exp_wr);
        end

        // ---- random keys ----
        for (int r = 0; r < 3; r++) begin
            rk = 24'($urandom);
            run_case($sformatf("rand%0d", r), rk, 0, EXP_FIN, EXP_WR);
        end

        // ---- reset in the middle of a run ----
        preload();
        key = 24'h123456; start = 1'b1;
        @(posedge clock); cyc = 1;
        @(negedge clock); start = 1'b0;
        while (cyc < 900) begin
            @(posedge clock); cyc++;
            @(negedge clock);
        end
        while (!s_wren && cyc < 920) begin
            @(posedge clock); cyc++;
            @(negedge clock);
        end
        check("midrst_wren_before", s_wren, 1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_wren", s_wren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_address", address, 0);
        @(posedge clock); @(negedge clock);
        check("midrst_hold_busy", busy, 0);
        reset_n = 1'b1;
        $display("txn midrun_reset: cycle=%0d busy=%0d s_wren=%0d", cyc, busy, s_wren);
        run_case("after_reset", 24'h123456, 0, EXP_FIN, EXP_WR);

        check("wren_while_idle", bad_wren, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
